// File: rtl/rf_dump_streamer.sv
// Sweeps the debug register-file read port and streams a framed dump:
// 0xA5 header, {addr, data[31:24..7:0]} per register, then an XOR checksum byte.
module rf_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rf_ra_o,
  input  logic [DATA_W-1:0] rf_rd_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_CSUM
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;

  assign xfer = tx_valid_q & tx_ready_i;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_HDR;
          k_d        = '0;
          csum_d     = 8'h00;
          tx_data_d  = 8'hA5;
          tx_valid_d = 1'b1;
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d    = S_LOAD;
          tx_valid_d = 1'b0;
        end
      end
      S_LOAD: begin
        // rf_ra has held k for this whole cycle, so rf_rd is settled here.
        shift_d    = rf_rd_i;
        idx_d      = 3'd0;
        tx_data_d  = 8'(k_q);
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          csum_d = csum_q ^ tx_data_q;
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd4) begin
            if (k_q == LAST_K) begin
              state_d   = S_CSUM;
              tx_data_d = csum_q ^ tx_data_q;
            end else begin
              state_d    = S_LOAD;
              k_d        = k_q + 1'b1;
              tx_valid_d = 1'b0;
            end
          end else begin
            tx_data_d = shift_q[DATA_W-1 -: 8];
            shift_d   = shift_q << 8;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d    = S_IDLE;
          k_d        = '0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        k_d        = '0;
        tx_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      idx_q      <= 3'd0;
      shift_q    <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rf_ra_o    = k_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Bench for rf_dump_streamer: frames checked against a byte-list model built
// directly from the frame definition, with random back-pressure and corner cases.
module tb_rf_dump_streamer;

  localparam int N  = 32;
  localparam int NB = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, txr, busy, done, txv;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [7:0]  txd;

  logic        start_b, txr_b, busy_b, done_b, txv_b;
  logic [4:0]  ra_b;
  logic [31:0] rd_b;
  logic [7:0]  txd_b;

  logic [31:0] regs [0:31];
  assign rd   = regs[ra];
  assign rd_b = regs[ra_b];

  rf_dump_streamer #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .rf_ra_o(ra), .rf_rd_i(rd),
    .tx_data_o(txd), .tx_valid_o(txv), .tx_ready_i(txr), .busy_o(busy), .done_o(done)
  );

  rf_dump_streamer #(.NUM_REGS(NB), .ADDR_W(5), .DATA_W(32)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .start_i(start_b), .rf_ra_o(ra_b), .rf_rd_i(rd_b),
    .tx_data_o(txd_b), .tx_valid_o(txv_b), .tx_ready_i(txr_b), .busy_o(busy_b), .done_o(done_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_pct = 100;

  logic [7:0] got_q[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  logic [4:0] ra_log[$];
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, hold_err = 0;
  int done_cnt_b = 0, done_cyc_b = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic [4:0] last_ra_b = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    txr = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99, 0)) < ready_pct);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (txv && txr) got_q.push_back(txd);
      if (pend && (!txv || txd != pend_data)) hold_err <= hold_err + 1;
      pend      <= txv && !txr;
      pend_data <= txd;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (txv_b && txr_b) got_b.push_back(txd_b);
      if (done_b) begin
        done_cnt_b <= done_cnt_b + 1;
        done_cyc_b <= cyc;
      end
      if (ra_b != last_ra_b) ra_log.push_back(ra_b);
      last_ra_b <= ra_b;
    end else begin
      pend <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference frame straight from the frame definition.
  task automatic push_frame(input int n);
    logic [7:0]  cs, b;
    logic [31:0] w;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < n; k++) begin
      w = regs[k];
      for (int j = 0; j < 5; j++) begin
        b = (j == 0) ? 8'(k) : 8'(w >> (8 * (4 - j)));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_frame(input string name, input bit use_b, input int base);
    int n, bad;
    logic [7:0] g;
    n   = use_b ? got_b.size() - base : got_q.size() - base;
    bad = 0;
    chk({name, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      g = use_b ? got_b[base + i] : got_q[base + i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        bad++;
        if (bad <= 4) $display("FAIL %s byte %0d: got %02h expected %02h", name, i, g, exp_q[i]);
      end
    end
  endtask

  task automatic set_regs(input int p);
    for (int k = 0; k < 32; k++) begin
      case (p)
        1:       regs[k] = (k == 5) ? 32'h12345678 : 32'h0;
        2:       regs[k] = 32'hA0000000 + 32'(k);
        3:       regs[k] = (k == 31) ? 32'h000000FF : 32'h0;
        4:       regs[k] = $urandom;
        default: regs[k] = 32'h0;
      endcase
    end
  endtask

  task automatic do_start(input bit use_b, output int c0);
    @(posedge clk);
    #1;
    if (use_b) start_b = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    start   = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (use_b ? done_b : done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    int         pattern;
    int         ready_pct;
    logic [7:0] exp_csum;
    bit         csum_known;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c0, base, bd, bb, bh;
    string nm;

    vecs[0] = '{0, 100, 8'h00, 1'b1};
    vecs[1] = '{1, 100, 8'h08, 1'b1};
    vecs[2] = '{2, 100, 8'h00, 1'b1};
    vecs[3] = '{2,  50, 8'h00, 1'b1};
    vecs[4] = '{3, 100, 8'hFF, 1'b1};
    vecs[5] = '{4,  30, 8'h00, 1'b0};
    vecs[6] = '{4, 100, 8'h00, 1'b0};

    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; txr_b = 1'b1;
    set_regs(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ra", 32'(ra), 0);
    chk("rst_txd", 32'(txd), 0);
    chk("rst_txv", 32'(txv), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[v]) begin
      nm = $sformatf("vec%0d", v);
      set_regs(vecs[v].pattern);
      ready_pct = vecs[v].ready_pct;
      exp_q.delete();
      push_frame(N);
      base = got_q.size(); bd = done_cnt; bb = busy_cnt; bh = hold_err;
      do_start(1'b0, c0);
      wait_done(1'b0, nm);
      repeat (3) @(negedge clk);
      cmp_frame(nm, 1'b0, base);
      chk({nm, "_len162"}, got_q.size() - base, 2 + 5 * N);
      if (vecs[v].csum_known) chk({nm, "_csum"}, 32'(got_q[got_q.size() - 1]), 32'(vecs[v].exp_csum));
      chk({nm, "_done_cnt"}, done_cnt - bd, 1);
      chk({nm, "_hold"}, hold_err - bh, 0);
      if (vecs[v].ready_pct >= 100) begin
        chk({nm, "_done_cyc"}, done_cyc - c0, 2 + 6 * N);
        chk({nm, "_busy_cyc"}, busy_cnt - bb, 2 + 6 * N);
      end
      $display("%s: pattern %0d ready %0d%% frame %0d bytes", nm, vecs[v].pattern, vecs[v].ready_pct, got_q.size() - base);
    end

    // start re-pulsed mid-dump, then a new start during the done cycle
    ready_pct = 100;
    set_regs(2);
    exp_q.delete();
    push_frame(N);
    push_frame(N);
    base = got_q.size(); bd = done_cnt;
    do_start(1'b0, c0);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (96) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, "restart1");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, "restart2");
    repeat (3) @(negedge clk);
    cmp_frame("restart", 1'b0, base);
    chk("restart_done_cnt", done_cnt - bd, 2);
    chk("restart_done_cyc", done_cyc - c0, 2 * (2 + 6 * N) + 1);
    $display("restart: two frames %0d bytes", got_q.size() - base);

    // reset in SEND of register 10
    set_regs(4);
    exp_q.delete();
    push_frame(N);
    do_start(1'b0, c0);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (txv && ra == 5'd10) begin
          hit = 1'b1;
          break;
        end
      end
      chk("mid_reset_reach_k10", 32'(hit), 1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bd = done_cnt;
    @(negedge clk);
    chk("mid_reset_txv", 32'(txv), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    chk("mid_reset_ra", 32'(ra), 0);
    chk("mid_reset_done", 32'(done), 0);
    repeat (10) @(negedge clk);
    chk("mid_reset_no_done", done_cnt - bd, 0);
    base = got_q.size();
    do_start(1'b0, c0);
    wait_done(1'b0, "after_reset");
    repeat (3) @(negedge clk);
    cmp_frame("after_reset", 1'b0, base);
    $display("after_reset: frame %0d bytes", got_q.size() - base);

    // NUM_REGS=4 instance
    set_regs(4);
    exp_q.delete();
    push_frame(NB);
    base = got_b.size(); bd = ra_log.size();
    do_start(1'b1, c0);
    wait_done(1'b1, "nb4");
    repeat (3) @(negedge clk);
    cmp_frame("nb4", 1'b1, base);
    chk("nb4_len22", got_b.size() - base, 22);
    chk("nb4_done_cyc", done_cyc_b - c0, 2 + 6 * NB);
    chk("nb4_done_cnt", done_cnt_b, 1);
    chk("nb4_ra_walk_len", ra_log.size() - bd, 4);
    if (ra_log.size() - bd == 4) begin
      chk("nb4_ra1", 32'(ra_log[bd]), 1);
      chk("nb4_ra2", 32'(ra_log[bd + 1]), 2);
      chk("nb4_ra3", 32'(ra_log[bd + 2]), 3);
      chk("nb4_ra_idle", 32'(ra_log[bd + 3]), 0);
    end
    $display("nb4: frame %0d bytes", got_b.size() - base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
